cache_interface: RTL and testbench
==================================

Name: cache_interface

Overview:
- Two-way set-associative, write-back, write-allocate cache between a CPU-side request port and a next-level memory port.
- One instance serves data and one serves instructions. The trace driver issues CPU-side reads and writes; the next-level port connects to the lower memory model.
- Keeps hit, miss and eviction statistics for the monitors.

Parameters:
- DATAWIDTH, 32, data word width in bits; must be a power of two, at least 8.
- ADDRESSWIDTH, 32, byte address width.
- NUM_SETS, 64, number of sets; must be a power of two.
- One word per line. Offset bits OB = log2(DATAWIDTH/8); index bits IB = log2(NUM_SETS); tag = ADDRESSWIDTH-OB-IB upper bits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request valid; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDRESSWIDTH  byte address; low OB bits ignored
- cpu_wdata  in  DATAWIDTH  write data
- cpu_rdata  out  DATAWIDTH  read data; valid when cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- nxt_req  out  1  next-level request; held until nxt_ack
- nxt_we  out  1  1 = write-back, 0 = fill
- nxt_addr  out  ADDRESSWIDTH  line address; low OB bits zero
- nxt_wdata  out  DATAWIDTH  victim data
- nxt_rdata  in  DATAWIDTH  fill data; valid with nxt_ack
- nxt_ack  in  1  next-level completion
- hit_count, miss_count, evict_count  out  32 each  statistics

Behaviour:
- Reset (async, reset_n=0): all valid, dirty and LRU bits cleared; state IDLE; every output 0; counters 0. Reset mid-transaction aborts it; nxt_req and cpu_ack drop immediately and no partial state is kept.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
- IDLE: cpu_req sampled at edge N; address and data are registered; go to LOOKUP.
- LOOKUP, hit: a way is valid with matching tag.
  - Read returns that way's data; write updates it and sets dirty.
  - LRU points to the other way; hit_count++.
  - cpu_ack asserted for the cycle after edge N+1; this is a 2-cycle hit latency.
- LOOKUP, miss: miss_count++.
  - Victim choice: way0 if invalid, else way1 if invalid, else the LRU way.
  - Victim valid and dirty: evict_count++, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK: nxt_req=1, nxt_we=1, nxt_addr = {victim tag, index, OB zeros}, nxt_wdata = victim data, all held stable. On nxt_ack, go to FILL.
- FILL: nxt_req=1, nxt_we=0, nxt_addr = {request tag, index, zeros}. On nxt_ack:
  - Install nxt_rdata in the victim way with valid=1.
  - Write request: merge cpu_wdata and set dirty=1. Read request: dirty=0.
  - LRU points to the other way; go to RESPOND.
- RESPOND: cpu_ack=1 for one cycle with cpu_rdata = line data (the written value for a write); return to IDLE.
- nxt_req drops in the cycle after nxt_ack. nxt_ack while nxt_req=0 is ignored.
- cpu_req deasserting before ack is illegal; the cache completes the transaction anyway.
- Back-to-back requests: a new request is sampled no earlier than the edge after cpu_ack.
- Counters wrap modulo 2^32. One miss that causes an eviction increments both miss_count and evict_count.
- A write hit on a dirty line causes no next-level traffic.

Decomposition:
- Shared package cachepkg holds:
  - state_t enum (IDLE, LOOKUP, WRITEBACK, FILL, RESPOND)
  - line_t struct (valid, dirty, tag, data)
  - set_t struct (line_t way[2], lru bit)
  - stat_t (32-bit counter type)
- Sub-module cache_set_store holds the NUM_SETS×2 line array and the LRU bits.
  - Read by index, combinational.
  - Write one way plus LRU per clock.
  - Async reset of valid, dirty and LRU.

Test Plan:
- Cold read addr 0x0000_0100, next level returns 0xDEAD_BEEF: exactly one fill at 0x100; cpu_rdata=0xDEAD_BEEF; miss=1, hit=0. Repeat read: 2-cycle ack, no nxt_req; hit=1.
- Write 0x1234_5678 to 0x100 after the fill: hit, no next-level traffic. Then read A=0x100, B=0x100+NUM_SETS×4 (fills way1) and C=0x100+2×NUM_SETS×4, in that order. C evicts dirty A (LRU): write-back to 0x100 with 0x1234_5678 precedes the fill of C; evict_count=1.
- Read 0x100, read 0x100+NUM_SETS×4, read 0x100 again, then read 0x100+2×NUM_SETS×4: the second line (LRU) is evicted; it is clean, so there is no write-back; evict_count unchanged.
- Next level delays nxt_ack 5 cycles during fill: nxt_req and nxt_addr stay stable all 5 cycles; cpu_ack stays 0 until RESPOND.
- Assert reset_n=0 during WRITEBACK: nxt_req=0 at once; counters=0. Re-read the previously cached address: miss and fill.
- Write miss at 0x0000_0040 with cpu_wdata 0xA5A5_A5A5, fill returns 0: line is installed dirty; read 0x40 returns 0xA5A5_A5A5 as a hit.

Source files
------------

// File: rtl/cache_interface_pkg.sv
// Shared types and cache geometry for the two-way set-associative cache.
// Geometry lives here so the structs below and every user agree on field widths.
package cachepkg;

  localparam int DATAWIDTH    = 32;
  localparam int ADDRESSWIDTH = 32;
  localparam int NUM_SETS     = 64;
  localparam int OB           = $clog2(DATAWIDTH / 8);
  localparam int IB           = $clog2(NUM_SETS);
  localparam int TB           = ADDRESSWIDTH - OB - IB;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    RESPOND
  } state_t;

  typedef logic [31:0] stat_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TB-1:0]        tag;
    logic [DATAWIDTH-1:0] data;
  } line_t;

  // lru names the least recently used way
  typedef struct packed {
    line_t [1:0] way;
    logic        lru;
  } set_t;

  function automatic logic [ADDRESSWIDTH-1:0] line_addr(input logic [TB-1:0] tag,
                                                        input logic [IB-1:0] idx);
    return {tag, idx, {OB{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_interface_if.sv
// Request/acknowledge bus used on both the CPU side and the next-level side.
interface cache_interface_if;
  import cachepkg::*;

  logic                    req;
  logic                    we;
  logic [ADDRESSWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0]    wdata;
  logic [DATAWIDTH-1:0]    rdata;
  logic                    ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cache_interface_set_store.sv
// Two-way line storage plus per-set LRU bits; combinational read, one way written per clock.
module cache_set_store
  import cachepkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [IB-1:0] i_rd_idx,
  output set_t          o_set,
  input  logic          i_line_we,
  input  logic [IB-1:0] i_wr_idx,
  input  logic          i_wr_way,
  input  line_t         i_wr_line,
  input  logic          i_lru_we,
  input  logic          i_lru
);

  logic [NUM_SETS-1:0] r_lru;
  line_t               w_lines [2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lru <= '0;
    end else if (i_lru_we) begin
      r_lru[i_wr_idx] <= i_lru;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [NUM_SETS-1:0]  r_valid;
      logic [NUM_SETS-1:0]  r_dirty;
      logic [TB-1:0]        r_tag  [NUM_SETS];
      logic [DATAWIDTH-1:0] r_data [NUM_SETS];
      logic                 w_we;

      assign w_we = i_line_we && (i_wr_way == 1'(gi));

      // Only the status bits are reset; tag and data stay in plain RAM
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_valid <= '0;
          r_dirty <= '0;
        end else if (w_we) begin
          r_valid[i_wr_idx] <= i_wr_line.valid;
          r_dirty[i_wr_idx] <= i_wr_line.dirty;
        end
      end

      always_ff @(posedge i_clk) begin
        if (w_we) begin
          r_tag[i_wr_idx]  <= i_wr_line.tag;
          r_data[i_wr_idx] <= i_wr_line.data;
        end
      end

      assign w_lines[gi] = '{valid: r_valid[i_rd_idx], dirty: r_dirty[i_rd_idx],
                             tag: r_tag[i_rd_idx], data: r_data[i_rd_idx]};
    end
  endgenerate

  assign o_set = {w_lines[1], w_lines[0], r_lru[i_rd_idx]};

endmodule

// File: rtl/cache_interface.sv
// Two-way set-associative write-back, write-allocate cache between a CPU port and next-level memory.
module cache_interface
  import cachepkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  cache_interface_if.slave          cpu,
  cache_interface_if.master         nxt,
  output stat_t                     hit_count,
  output stat_t                     miss_count,
  output stat_t                     evict_count
);

  state_t                  r_state;
  logic                    r_we;
  logic [TB-1:0]           r_tag;
  logic [IB-1:0]           r_idx;
  logic [DATAWIDTH-1:0]    r_wdata;
  logic                    r_victim;
  logic                    r_cpu_ack;
  logic [DATAWIDTH-1:0]    r_cpu_rdata;
  logic                    r_nxt_req;
  logic                    r_nxt_we;
  logic [ADDRESSWIDTH-1:0] r_nxt_addr;
  logic [DATAWIDTH-1:0]    r_nxt_wdata;
  stat_t                   r_hit_count;
  stat_t                   r_miss_count;
  stat_t                   r_evict_count;

  set_t  w_set;
  logic  w_hit0, w_hit1, w_hit, w_hit_way, w_victim, w_fill_done;
  line_t w_vline;
  logic  w_line_we, w_lru_we, w_wr_way, w_lru_val;
  line_t w_wr_line;

  cache_set_store u_store (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_rd_idx  (r_idx),
    .o_set     (w_set),
    .i_line_we (w_line_we),
    .i_wr_idx  (r_idx),
    .i_wr_way  (w_wr_way),
    .i_wr_line (w_wr_line),
    .i_lru_we  (w_lru_we),
    .i_lru     (w_lru_val)
  );

  always_comb begin
    w_hit0      = w_set.way[0].valid && (w_set.way[0].tag == r_tag);
    w_hit1      = w_set.way[1].valid && (w_set.way[1].tag == r_tag);
    w_hit       = w_hit0 || w_hit1;
    w_hit_way   = !w_hit0;
    w_victim    = !w_set.way[0].valid ? 1'b0 : (!w_set.way[1].valid ? 1'b1 : w_set.lru);
    w_vline     = w_set.way[w_victim];
    w_fill_done = (r_state == FILL) && r_nxt_req && nxt.ack;

    w_line_we = 1'b0;
    w_lru_we  = 1'b0;
    w_wr_way  = 1'b0;
    w_lru_val = 1'b0;
    w_wr_line = '0;
    if (r_state == LOOKUP && w_hit) begin
      w_lru_we  = 1'b1;
      w_lru_val = ~w_hit_way;
      w_wr_way  = w_hit_way;
      if (r_we) begin
        w_line_we = 1'b1;
        w_wr_line = '{valid: 1'b1, dirty: 1'b1, tag: r_tag, data: r_wdata};
      end
    end else if (w_fill_done) begin
      w_line_we = 1'b1;
      w_wr_way  = r_victim;
      w_lru_we  = 1'b1;
      w_lru_val = ~r_victim;
      w_wr_line = '{valid: 1'b1, dirty: r_we, tag: r_tag,
                    data: r_we ? r_wdata : nxt.rdata};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_tag         <= '0;
      r_idx         <= '0;
      r_wdata       <= '0;
      r_victim      <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_cpu_rdata   <= '0;
      r_nxt_req     <= 1'b0;
      r_nxt_we      <= 1'b0;
      r_nxt_addr    <= '0;
      r_nxt_wdata   <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
      r_evict_count <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          // The request just acknowledged may still be held; skip it
          if (cpu.req && !r_cpu_ack) begin
            r_we    <= cpu.we;
            r_tag   <= cpu.addr[ADDRESSWIDTH-1 -: TB];
            r_idx   <= cpu.addr[OB +: IB];
            r_wdata <= cpu.wdata;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= r_we ? r_wdata : w_set.way[w_hit_way].data;
            r_state     <= IDLE;
          end else begin
            r_miss_count <= r_miss_count + 32'd1;
            r_victim     <= w_victim;
            r_nxt_req    <= 1'b1;
            if (w_vline.valid && w_vline.dirty) begin
              r_evict_count <= r_evict_count + 32'd1;
              r_nxt_we      <= 1'b1;
              r_nxt_addr    <= line_addr(w_vline.tag, r_idx);
              r_nxt_wdata   <= w_vline.data;
              r_state       <= WRITEBACK;
            end else begin
              r_nxt_we   <= 1'b0;
              r_nxt_addr <= line_addr(r_tag, r_idx);
              r_state    <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (r_nxt_req && nxt.ack) begin
            r_nxt_req <= 1'b0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          // After a write-back, req is low for one cycle before the fill is issued
          if (!r_nxt_req) begin
            r_nxt_req  <= 1'b1;
            r_nxt_we   <= 1'b0;
            r_nxt_addr <= line_addr(r_tag, r_idx);
          end else if (nxt.ack) begin
            r_nxt_req   <= 1'b0;
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= r_we ? r_wdata : nxt.rdata;
            r_state     <= RESPOND;
          end
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu.ack     = r_cpu_ack;
  assign cpu.rdata   = r_cpu_rdata;
  assign nxt.req     = r_nxt_req;
  assign nxt.we      = r_nxt_we;
  assign nxt.addr    = r_nxt_addr;
  assign nxt.wdata   = r_nxt_wdata;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
  assign evict_count = r_evict_count;

endmodule

// File: tb/tb_cache_interface.sv
// Directed bench: vector table for hit/miss/eviction traffic, plus hand sequences for delay and reset.
module tb_cache_interface;
  import cachepkg::*;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  stat_t hit_count, miss_count, evict_count;

  cache_interface_if cpu ();
  cache_interface_if nxt ();

  cache_interface dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .cpu         (cpu),
    .nxt         (nxt),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .evict_count (evict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } nxt_txn_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] fill;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_nxt;
    logic        n0_we;
    logic [31:0] n0_addr;
    logic [31:0] n0_data;
    logic [31:0] exp_h;
    logic [31:0] exp_m;
    logic [31:0] exp_e;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  int          held = 0;
  logic [31:0] fill_data = '0;
  logic [31:0] hold_addr = '0;
  nxt_txn_t    nxt_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Next-level memory model: acknowledges after mem_delay waiting cycles
  initial begin
    nxt.ack   = 1'b0;
    nxt.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        nxt.ack  = 1'b0;
        wait_cnt = 0;
      end else if (nxt.ack) begin
        nxt.ack = 1'b0;
      end else if (nxt.req) begin
        if (wait_cnt == 0) begin
          hold_addr = nxt.addr;
          held      = 0;
        end else begin
          chk("nxt_addr_stable", nxt.addr, hold_addr);
          chk("cpu_ack_quiet", {31'b0, cpu.ack}, 32'd0);
        end
        held++;
        if (wait_cnt < mem_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt  = 0;
          nxt.ack   = 1'b1;
          nxt.rdata = nxt.we ? 32'd0 : fill_data;
          nxt_log.push_back('{we: nxt.we, addr: nxt.addr, data: nxt.wdata});
        end
      end
    end
  end

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    @(posedge clk);
    #1;
    cpu.req   = 1'b1;
    cpu.we    = we;
    cpu.addr  = addr;
    cpu.wdata = wdata;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpu.ack && lat < 200);
    chk("cpu_ack_timeout", {31'b0, cpu.ack}, 32'd1);
    rdata   = cpu.rdata;
    cpu.req = 1'b0;
    $display("txn we=%0d addr=%h wdata=%h -> rdata=%h lat=%0d nxt_ops=%0d hit=%0d miss=%0d evict=%0d",
             we, addr, wdata, rdata, lat, nxt_log.size(), hit_count, miss_count, evict_count);
  endtask

  vec_t        vecs[17];
  logic [31:0] rd;
  int          lat;

  initial begin
    cpu.req   = 1'b0;
    cpu.we    = 1'b0;
    cpu.addr  = '0;
    cpu.wdata = '0;

    vecs[0]  = '{1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 0, 1, 1'b0, 32'h100, 32'h0,        32'd0, 32'd1,  32'd0};
    vecs[1]  = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 32'hDEADBEEF, 2, 0, 1'b0, 32'h0,   32'h0,        32'd1, 32'd1,  32'd0};
    vecs[2]  = '{1'b1, 32'h100, 32'h12345678, 32'h0,        1'b0, 32'h0,        2, 0, 1'b0, 32'h0,   32'h0,        32'd2, 32'd1,  32'd0};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 32'h12345678, 2, 0, 1'b0, 32'h0,   32'h0,        32'd3, 32'd1,  32'd0};
    vecs[4]  = '{1'b0, 32'h200, 32'h0,        32'h22222222, 1'b1, 32'h22222222, 0, 1, 1'b0, 32'h200, 32'h0,        32'd3, 32'd2,  32'd0};
    vecs[5]  = '{1'b0, 32'h300, 32'h0,        32'h33333333, 1'b1, 32'h33333333, 0, 2, 1'b1, 32'h100, 32'h12345678, 32'd3, 32'd3,  32'd1};
    vecs[6]  = '{1'b0, 32'h104, 32'h0,        32'h11110001, 1'b1, 32'h11110001, 0, 1, 1'b0, 32'h104, 32'h0,        32'd3, 32'd4,  32'd1};
    vecs[7]  = '{1'b0, 32'h204, 32'h0,        32'h22220002, 1'b1, 32'h22220002, 0, 1, 1'b0, 32'h204, 32'h0,        32'd3, 32'd5,  32'd1};
    vecs[8]  = '{1'b0, 32'h104, 32'h0,        32'h0,        1'b1, 32'h11110001, 2, 0, 1'b0, 32'h0,   32'h0,        32'd4, 32'd5,  32'd1};
    vecs[9]  = '{1'b0, 32'h304, 32'h0,        32'h33330003, 1'b1, 32'h33330003, 0, 1, 1'b0, 32'h304, 32'h0,        32'd4, 32'd6,  32'd1};
    vecs[10] = '{1'b0, 32'h104, 32'h0,        32'h0,        1'b1, 32'h11110001, 2, 0, 1'b0, 32'h0,   32'h0,        32'd5, 32'd6,  32'd1};
    vecs[11] = '{1'b0, 32'h204, 32'h0,        32'h22229999, 1'b1, 32'h22229999, 0, 1, 1'b0, 32'h204, 32'h0,        32'd5, 32'd7,  32'd1};
    vecs[12] = '{1'b1, 32'h040, 32'hA5A5A5A5, 32'h0,        1'b1, 32'hA5A5A5A5, 0, 1, 1'b0, 32'h040, 32'h0,        32'd5, 32'd8,  32'd1};
    vecs[13] = '{1'b0, 32'h040, 32'h0,        32'h0,        1'b1, 32'hA5A5A5A5, 2, 0, 1'b0, 32'h0,   32'h0,        32'd6, 32'd8,  32'd1};
    vecs[14] = '{1'b1, 32'h040, 32'h5A5A5A5A, 32'h0,        1'b0, 32'h0,        2, 0, 1'b0, 32'h0,   32'h0,        32'd7, 32'd8,  32'd1};
    vecs[15] = '{1'b0, 32'h140, 32'h0,        32'h00000140, 1'b1, 32'h00000140, 0, 1, 1'b0, 32'h140, 32'h0,        32'd7, 32'd9,  32'd1};
    vecs[16] = '{1'b0, 32'h240, 32'h0,        32'h00000240, 1'b1, 32'h00000240, 0, 2, 1'b1, 32'h040, 32'h5A5A5A5A, 32'd7, 32'd10, 32'd2};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack", {31'b0, cpu.ack}, 32'd0);
    chk("rst_cpu_rdata", cpu.rdata, 32'd0);
    chk("rst_nxt_req", {31'b0, nxt.req}, 32'd0);
    chk("rst_nxt_addr", nxt.addr, 32'd0);
    chk("rst_hit", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    chk("rst_evict", evict_count, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      fill_data = vecs[i].fill;
      nxt_log.delete();
      cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].exp_lat > 0) chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_nxt_ops", i), nxt_log.size(), vecs[i].exp_nxt);
      if (vecs[i].exp_nxt > 0 && nxt_log.size() > 0) begin
        chk($sformatf("v%0d_nxt0_we", i), {31'b0, nxt_log[0].we}, {31'b0, vecs[i].n0_we});
        chk($sformatf("v%0d_nxt0_addr", i), nxt_log[0].addr, vecs[i].n0_addr);
        if (vecs[i].n0_we) chk($sformatf("v%0d_nxt0_wdata", i), nxt_log[0].data, vecs[i].n0_data);
      end
      if (vecs[i].exp_nxt == 2 && nxt_log.size() == 2) begin
        chk($sformatf("v%0d_nxt1_we", i), {31'b0, nxt_log[1].we}, 32'd0);
        chk($sformatf("v%0d_nxt1_addr", i), nxt_log[1].addr, vecs[i].addr);
      end
      chk($sformatf("v%0d_hits", i), hit_count, vecs[i].exp_h);
      chk($sformatf("v%0d_misses", i), miss_count, vecs[i].exp_m);
      chk($sformatf("v%0d_evicts", i), evict_count, vecs[i].exp_e);
    end

    // Fill held off by five cycles: request must stay stable throughout
    mem_delay = 5;
    fill_data = 32'hCAFE0508;
    nxt_log.delete();
    cpu_access(1'b0, 32'h508, 32'h0, rd, lat);
    chk("delay_rdata", rd, 32'hCAFE0508);
    chk("delay_nxt_ops", nxt_log.size(), 32'd1);
    chk("delay_held_cycles", held, 32'd6);
    chk("delay_misses", miss_count, 32'd11);
    mem_delay = 0;

    // Dirty line in set 3 way0, clean line in way1, way0 left as LRU
    fill_data = 32'h0;
    cpu_access(1'b1, 32'h10C, 32'h77777777, rd, lat);
    fill_data = 32'h00002020;
    cpu_access(1'b0, 32'h20C, 32'h0, rd, lat);

    // Reset while the write-back is outstanding
    mem_delay = 20;
    nxt_log.delete();
    @(posedge clk);
    #1;
    cpu.req  = 1'b1;
    cpu.we   = 1'b0;
    cpu.addr = 32'h30C;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (nxt.req && nxt.we) break;
    end
    chk("wb_started", {31'b0, nxt.req && nxt.we}, 32'd1);
    chk("wb_addr", nxt.addr, 32'h10C);
    chk("wb_wdata", nxt.wdata, 32'h77777777);
    reset_n = 1'b0;
    #1;
    chk("abort_nxt_req", {31'b0, nxt.req}, 32'd0);
    chk("abort_cpu_ack", {31'b0, cpu.ack}, 32'd0);
    chk("abort_hits", hit_count, 32'd0);
    chk("abort_misses", miss_count, 32'd0);
    chk("abort_evicts", evict_count, 32'd0);
    cpu.req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_delay = 0;

    fill_data = 32'h0000F00D;
    nxt_log.delete();
    cpu_access(1'b0, 32'h10C, 32'h0, rd, lat);
    chk("reread_rdata", rd, 32'h0000F00D);
    chk("reread_nxt_ops", nxt_log.size(), 32'd1);
    if (nxt_log.size() > 0) begin
      chk("reread_fill_we", {31'b0, nxt_log[0].we}, 32'd0);
      chk("reread_fill_addr", nxt_log[0].addr, 32'h10C);
    end
    chk("reread_misses", miss_count, 32'd1);
    chk("reread_hits", hit_count, 32'd0);
    chk("reread_evicts", evict_count, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
